// File: rtl/la_ioring_ctrl.sv
// Core-side ioring controller: holds one shadow config word per IO cell, serially
// shifts the whole chain out over the ring, latches it into the pads and keeps the returned bits.
module la_ioring_ctrl #(
    parameter int unsigned RINGW  = 8,
    parameter int unsigned NCELLS = 16,
    parameter int unsigned CFGW   = 8,
    parameter int unsigned DIV    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    input  logic [$clog2(NCELLS)-1:0] wr_addr,
    input  logic [CFGW-1:0]           wr_data,
    output logic                      wr_err,
    input  logic                      commit,
    output logic                      busy,
    output logic                      done,
    input  logic [$clog2(NCELLS)-1:0] rd_addr,
    output logic [CFGW-1:0]           rd_data,
    inout  wire  [RINGW-1:0]          ioring
);

    localparam int unsigned AW    = $clog2(NCELLS);
    localparam int unsigned TOTAL = NCELLS * CFGW;
    localparam int unsigned DW    = $clog2(DIV + 1);
    localparam int unsigned BW    = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SLO,
        S_SHI,
        S_LATCH,
        S_DONE
    } state_t;

    state_t            state;
    logic [CFGW-1:0]   shadow   [NCELLS];
    logic [CFGW-1:0]   readback [NCELLS];
    logic [TOTAL-1:0]  shreg;
    logic [TOTAL-1:0]  cap;
    logic [TOTAL-1:0]  chain;
    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              sclk_q;
    logic              sdo_q;
    logic              latch_q;
    logic              sdi;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              div_last;
    logic              bit_last;

    // Chain vector with the highest cell in the most significant slot
    always_comb begin
        chain = '0;
        for (int i = 0; i < NCELLS; i++) begin
            chain[i*CFGW +: CFGW] = shadow[i];
        end
    end

    assign wr_in_range = ({1'b0, wr_addr} < (AW+1)'(NCELLS));
    assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(NCELLS));
    assign div_last    = (div_cnt == DW'(DIV - 1));
    assign bit_last    = (bit_cnt == BW'(TOTAL - 1));

    assign ioring[0] = sclk_q;
    assign ioring[1] = sdo_q;
    assign ioring[2] = latch_q;
    assign sdi       = ioring[3];

    generate
        if (RINGW > 4) begin : g_hiz
            assign ioring[RINGW-1:4] = {(RINGW-4){1'bz}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            shreg   <= '0;
            cap     <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            latch_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_err  <= 1'b0;
            rd_data <= '0;
            for (int i = 0; i < NCELLS; i++) begin
                shadow[i]   <= '0;
                readback[i] <= '0;
            end
        end else begin
            wr_err  <= 1'b0;
            done    <= 1'b0;
            rd_data <= rd_in_range ? readback[rd_addr] : '0;

            // Shadow writes only land while idle and in range
            if (wr_valid) begin
                if ((state == S_IDLE) && wr_in_range) begin
                    shadow[wr_addr] <= wr_data;
                end else begin
                    wr_err <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (commit) begin
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sdo_q   <= chain[TOTAL-1];
                    shreg   <= chain << 1;
                    sclk_q  <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= S_SLO;
                end
                S_SLO: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sclk_q  <= 1'b1;
                        state   <= S_SHI;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_SHI: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sclk_q  <= 1'b0;
                        // First sampled bit ends up at the top after TOTAL shifts
                        cap     <= {cap[TOTAL-2:0], sdi};
                        if (bit_last) begin
                            sdo_q   <= 1'b0;
                            latch_q <= 1'b1;
                            state   <= S_LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            sdo_q   <= shreg[TOTAL-1];
                            shreg   <= shreg << 1;
                            state   <= S_SLO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_LATCH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        latch_q <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_DONE: begin
                    for (int i = 0; i < NCELLS; i++) begin
                        readback[i] <= cap[i*CFGW +: CFGW];
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
